wb_sevenseg_mux: RTL and testbench

Parametrised Wishbone (pipelined, classic-compatible) seven-segment controller for 1..8 hex digits.
- Provides per-digit blanking, decimal points, raw-segment override and configurable segment polarity.
- Drives two output sets: static per-digit segment outputs, and a time-multiplexed scan bus (shared segments plus digit anodes) with PWM brightness.
- Sits on the peripheral bus beside the other wb_iodevice slaves.

---
 rtl/wb_sevenseg_mux.sv | 236 +++++++++++++++++++++++
 tb/tb_wb_sevenseg_mux.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sevenseg_mux.sv
// Wishbone seven-segment controller: static per-digit segments plus a PWM-dimmed scan bus.
// Latency: ack/read data 1 cycle after strobe; static outputs follow registers combinationally; scan outputs 1 cycle.
// Backpressure: none, o_wb_stall is tied low and every strobe is acked on the following cycle.
module wb_sevenseg_mux #(
   parameter int NUM_DIGITS     = 8,
   parameter int SCAN_DIV       = 1000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic                  i_wb_cyc,
   input  logic                  i_wb_stb,
   input  logic                  i_wb_we,
   input  logic [29:0]           i_wb_addr,
   input  logic [31:0]           i_wb_data,
   input  logic [3:0]            i_wb_sel,
   output logic                  o_wb_ack,
   output logic                  o_wb_stall,
   output logic [31:0]           o_wb_data,
   output logic [6:0]            o_displays [NUM_DIGITS],
   output logic [NUM_DIGITS-1:0] o_dp,
   output logic [7:0]            o_scan_seg,
   output logic [NUM_DIGITS-1:0] o_scan_an
);

   // Register-map addresses
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_CTRL = 2'd1;
   localparam logic [1:0] ADDR_RAW0 = 2'd2;
   localparam logic [1:0] ADDR_RAW1 = 2'd3;

   // Implemented bits of each register; digits beyond NUM_DIGITS have no storage
   localparam logic [7:0]  DIG_MASK  = 8'((9'd1 << NUM_DIGITS) - 9'd1);
   localparam logic [31:0] DATA_MASK = 32'((33'd1 << (4 * NUM_DIGITS)) - 33'd1);
   localparam logic [31:0] CTRL_MASK = {8'h0F, DIG_MASK, DIG_MASK, DIG_MASK};
   localparam logic [31:0] RAW0_MASK = {(NUM_DIGITS > 3) ? 8'h7F : 8'h00,
                                        (NUM_DIGITS > 2) ? 8'h7F : 8'h00,
                                        (NUM_DIGITS > 1) ? 8'h7F : 8'h00,
                                        8'h7F};
   localparam logic [31:0] RAW1_MASK = {(NUM_DIGITS > 7) ? 8'h7F : 8'h00,
                                        (NUM_DIGITS > 6) ? 8'h7F : 8'h00,
                                        (NUM_DIGITS > 5) ? 8'h7F : 8'h00,
                                        (NUM_DIGITS > 4) ? 8'h7F : 8'h00};
   localparam logic [31:0] CTRL_RST  = 32'h0F00_0000;

   // XOR masks that turn active-high values into the pin polarity
   localparam logic [7:0]            SEG_POL = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] AN_POL  = {NUM_DIGITS{SEG_ACTIVE_LOW}};

   // Scan divider sizing; a 1-bit counter covers SCAN_DIV == 1
   localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [2:0]        IDX_LAST = 3'(NUM_DIGITS - 1);

   // Register file
   logic [31:0] data_q;
   logic [31:0] ctrl_q;
   logic [31:0] raw0_q;
   logic [31:0] raw1_q;

   // Bus response state
   logic        ack_q;
   logic [31:0] rdata_q;
   logic [31:0] rd_mux;

   // Output enable: holds outputs dark for the first cycle out of reset
   logic        out_en_q;

   // Scan state
   logic [DIV_W-1:0]      div_q;
   logic [2:0]            idx_q;
   logic [3:0]            pwm_q;
   logic                  pwm_gate;
   logic [7:0]            cur_seg;
   logic [NUM_DIGITS-1:0] an_hot;
   logic [7:0]            scan_seg_q;
   logic [NUM_DIGITS-1:0] scan_an_q;

   // Per-digit active-high segment/dp values
   logic [6:0]            seg_ah [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] dp_ah;

   logic wb_req;
   logic wb_wr;
   logic wb_rd;

   // Only addr[1:0] is decoded
   logic unused_addr;
   assign unused_addr = ^i_wb_addr[29:2];

   assign wb_req = i_wb_cyc & i_wb_stb;
   assign wb_wr  = wb_req & i_wb_we;
   assign wb_rd  = wb_req & ~i_wb_we;

   // Standard hex table, active-high, bit0=a .. bit6=g
   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   // Byte-lane merge of a write into an existing register, keeping only implemented bits
   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel,
                                              input logic [31:0] impl);
      logic [31:0] lanes;
      lanes = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
      return ((old_v & ~lanes) | (new_v & lanes)) & impl;
   endfunction

   // Read mux sees the registers before any write in the same cycle
   always_comb begin
      rd_mux = 32'h0;
      case (i_wb_addr[1:0])
         ADDR_DATA: rd_mux = data_q;
         ADDR_CTRL: rd_mux = ctrl_q;
         ADDR_RAW0: rd_mux = raw0_q;
         default:   rd_mux = raw1_q;
      endcase
   end

   // Register writes commit on the strobe edge, per byte lane
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         data_q <= 32'h0;
         ctrl_q <= CTRL_RST;
         raw0_q <= 32'h0;
         raw1_q <= 32'h0;
      end else if (wb_wr) begin
         case (i_wb_addr[1:0])
            ADDR_DATA: data_q <= lane_merge(data_q, i_wb_data, i_wb_sel, DATA_MASK);
            ADDR_CTRL: ctrl_q <= lane_merge(ctrl_q, i_wb_data, i_wb_sel, CTRL_MASK);
            ADDR_RAW0: raw0_q <= lane_merge(raw0_q, i_wb_data, i_wb_sel, RAW0_MASK);
            default:   raw1_q <= lane_merge(raw1_q, i_wb_data, i_wb_sel, RAW1_MASK);
         endcase
      end
   end

   // One registered ack per request; read data captured alongside it
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         ack_q   <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         ack_q   <= wb_req;
         rdata_q <= wb_rd ? rd_mux : 32'h0;
      end
   end

   // Dropping cyc abandons the cycle, so a pending ack is suppressed
   assign o_wb_ack   = ack_q & i_wb_cyc;
   assign o_wb_data  = o_wb_ack ? rdata_q : 32'h0;
   assign o_wb_stall = 1'b0;

   // Output enable rises on the first clock edge out of reset
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) out_en_q <= 1'b0;
      else            out_en_q <= 1'b1;
   end

   // Digit content selection: blank beats raw, raw beats hex decode
   always_comb begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
         seg_ah[k] = 7'h00;
         dp_ah[k]  = 1'b0;
         if (!ctrl_q[k]) begin
            if (ctrl_q[16+k])
               seg_ah[k] = (k < 4) ? raw0_q[8*(k%4) +: 7] : raw1_q[8*(k%4) +: 7];
            else
               seg_ah[k] = hex7(data_q[4*k +: 4]);
            dp_ah[k] = ctrl_q[8+k];
         end
      end
   end

   // Static outputs with polarity applied last
   for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_static
      assign o_displays[k] = out_en_q ? (seg_ah[k] ^ SEG_POL[6:0]) : SEG_POL[6:0];
      assign o_dp[k]       = out_en_q ? (dp_ah[k] ^ SEG_POL[7])     : SEG_POL[7];
   end

   // Select the digit currently being scanned and its anode
   always_comb begin
      cur_seg = 8'h00;
      an_hot  = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         an_hot[k] = (idx_q == 3'(k));
         if (idx_q == 3'(k)) cur_seg = {dp_ah[k], seg_ah[k]};
      end
   end

   assign pwm_gate = (pwm_q <= ctrl_q[27:24]);

   // Scan divider, digit index and free-running PWM counter, plus registered scan outputs
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         div_q      <= '0;
         idx_q      <= 3'd0;
         pwm_q      <= 4'd0;
         scan_seg_q <= SEG_POL;
         scan_an_q  <= AN_POL;
      end else begin
         pwm_q <= pwm_q + 4'd1;
         if (div_q == DIV_LAST) begin
            div_q <= '0;
            idx_q <= (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
         scan_seg_q <= pwm_gate ? (cur_seg ^ SEG_POL) : SEG_POL;
         scan_an_q  <= pwm_gate ? (an_hot ^ AN_POL)   : AN_POL;
      end
   end

   assign o_scan_seg = scan_seg_q;
   assign o_scan_an  = scan_an_q;

endmodule

// File: tb/tb_wb_sevenseg_mux.sv
// Directed bench for wb_sevenseg_mux: an 8-digit and a 3-digit instance share one bus.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: not applicable, the slave never stalls.
module tb_wb_sevenseg_mux;

   logic        clk;
   logic        rst_n;
   logic        cyc, stb, we;
   logic [29:0] addr;
   logic [31:0] wdat;
   logic [3:0]  sel;

   logic        ack8, stall8;
   logic [31:0] rdat8;
   logic [6:0]  disp8 [8];
   logic [7:0]  dp8;
   logic [7:0]  sseg8;
   logic [7:0]  san8;

   logic        ack3, stall3;
   logic [31:0] rdat3;
   logic [6:0]  disp3 [3];
   logic [2:0]  dp3;
   logic [7:0]  sseg3;
   logic [2:0]  san3;

   int n_cmp;
   int n_bad;

   wb_sevenseg_mux #(.NUM_DIGITS(8), .SCAN_DIV(2), .SEG_ACTIVE_LOW(1'b1)) dut8 (
      .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel),
      .o_wb_ack(ack8), .o_wb_stall(stall8), .o_wb_data(rdat8),
      .o_displays(disp8), .o_dp(dp8), .o_scan_seg(sseg8), .o_scan_an(san8)
   );

   wb_sevenseg_mux #(.NUM_DIGITS(3), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut3 (
      .i_clk(clk), .i_reset_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
      .i_wb_addr(addr), .i_wb_data(wdat), .i_wb_sel(sel),
      .o_wb_ack(ack3), .o_wb_stall(stall3), .o_wb_data(rdat3),
      .o_displays(disp3), .o_dp(dp3), .o_scan_seg(sseg3), .o_scan_an(san3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle();
      cyc = 1'b0; stb = 1'b0; we = 1'b0; addr = 30'd0; wdat = 32'h0; sel = 4'h0;
   endtask

   task automatic do_reset();
      bus_idle();
      rst_n = 1'b0;
      tick(); tick(); tick();
   endtask

   task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = {28'd0, a}; wdat = d; sel = s;
      tick();
      bus_idle();
      tick();
   endtask

   task automatic wb_read(input logic [1:0] a, output logic [31:0] d8, output logic [31:0] d3);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = {28'd0, a}; sel = 4'hF;
      tick();
      d8 = rdat8;
      d3 = rdat3;
      bus_idle();
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (disp8[0] !== 7'h7F || san3 !== 3'b111 || ack8 !== 1'b0 || rdat8 !== 32'h0) begin
         $display("FAIL in_reset disp0=%h an3=%b ack=%b rdat=%h required 7f/111/0/0", disp8[0], san3, ack8, rdat8); n_bad++; end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (disp8[3] !== 7'h7F || dp8 !== 8'hFF) begin
         $display("FAIL first_cycle_dark disp3=%h dp=%h required 7f/ff", disp8[3], dp8); n_bad++; end
      tick();
      for (int k = 0; k < 8; k++) begin
         n_cmp++; if (disp8[k] !== 7'h40) begin
            $display("FAIL reset_disp%0d got %h required 40", k, disp8[k]); n_bad++; end
      end
      n_cmp++; if (dp8 !== 8'hFF || dp3 !== 3'b111 || stall8 !== 1'b0) begin
         $display("FAIL reset_dp dp8=%h dp3=%b stall=%b required ff/111/0", dp8, dp3, stall8); n_bad++; end
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'd1; sel = 4'hF;
      #1;
      n_cmp++; if (ack8 !== 1'b0) begin
         $display("FAIL ack_same_cycle got %b required 0", ack8); n_bad++; end
      tick();
      n_cmp++; if (ack8 !== 1'b1 || rdat8 !== 32'h0F00_0000 || rdat3 !== 32'h0F00_0000) begin
         $display("FAIL ctrl_reset ack=%b d8=%h d3=%h required 1/0f000000/0f000000", ack8, rdat8, rdat3); n_bad++; end
      bus_idle();
      tick();
      n_cmp++; if (ack8 !== 1'b0 || rdat8 !== 32'h0) begin
         $display("FAIL ack_single ack=%b rdat=%h required 0/0", ack8, rdat8); n_bad++; end
   endtask

   task automatic test_hex();
      logic [31:0] r8, r3;
      wb_write(2'd0, 32'h1234_5678, 4'hF);
      wb_read(2'd0, r8, r3);
      n_cmp++; if (r8 !== 32'h1234_5678 || r3 !== 32'h0000_0678) begin
         $display("FAIL data_read d8=%h d3=%h required 12345678/00000678", r8, r3); n_bad++; end
      n_cmp++; if (disp8[0] !== 7'h00 || disp8[1] !== 7'h78 || disp8[3] !== 7'h12) begin
         $display("FAIL hex_low d0=%h d1=%h d3=%h required 00/78/12", disp8[0], disp8[1], disp8[3]); n_bad++; end
      n_cmp++; if (disp8[4] !== 7'h19 || disp8[7] !== 7'h79 || disp3[2] !== 7'h02) begin
         $display("FAIL hex_high d4=%h d7=%h d3_2=%h required 19/79/02", disp8[4], disp8[7], disp3[2]); n_bad++; end
   endtask

   task automatic test_back_to_back();
      wb_write(2'd0, 32'h0, 4'hF);
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'd0; wdat = 32'hFFFF_AAFF; sel = 4'b0010;
      tick();
      n_cmp++; if (ack8 !== 1'b1) begin
         $display("FAIL b2b_ack1 got %b required 1", ack8); n_bad++; end
      we = 1'b0; sel = 4'hF;
      tick();
      n_cmp++; if (ack8 !== 1'b1 || rdat8 !== 32'h0000_AA00 || rdat3 !== 32'h0000_0A00) begin
         $display("FAIL b2b_read ack=%b d8=%h d3=%h required 1/0000aa00/00000a00", ack8, rdat8, rdat3); n_bad++; end
      bus_idle();
      tick();
      n_cmp++; if (ack8 !== 1'b0 || rdat8 !== 32'h0) begin
         $display("FAIL b2b_idle ack=%b rdat=%h required 0/0", ack8, rdat8); n_bad++; end
      n_cmp++; if (disp8[2] !== 7'h08 || disp8[0] !== 7'h40) begin
         $display("FAIL b2b_disp d2=%h d0=%h required 08/40", disp8[2], disp8[0]); n_bad++; end
   endtask

   task automatic test_ctrl_raw();
      logic [31:0] r8, r3;
      wb_write(2'd1, 32'h0004_0201, 4'hF);
      wb_write(2'd2, 32'h8049_0000, 4'hF);
      n_cmp++; if (disp8[0] !== 7'h7F || disp8[2] !== 7'h36 || disp8[3] !== 7'h08) begin
         $display("FAIL ctrl_disp d0=%h d2=%h d3=%h required 7f/36/08", disp8[0], disp8[2], disp8[3]); n_bad++; end
      n_cmp++; if (dp8 !== 8'hFD) begin
         $display("FAIL ctrl_dp got %h required fd", dp8); n_bad++; end
      wb_read(2'd2, r8, r3);
      n_cmp++; if (r8 !== 32'h0049_0000 || r3 !== 32'h0049_0000) begin
         $display("FAIL raw0_read d8=%h d3=%h required 00490000/00490000", r8, r3); n_bad++; end
      wb_read(2'd1, r8, r3);
      n_cmp++; if (r8 !== 32'h0004_0201 || r3 !== 32'h0004_0201) begin
         $display("FAIL ctrl_read d8=%h d3=%h required 00040201/00040201", r8, r3); n_bad++; end
      wb_write(2'd3, 32'hFFFF_FFFF, 4'hF);
      wb_read(2'd3, r8, r3);
      n_cmp++; if (r8 !== 32'h7F7F_7F7F || r3 !== 32'h0) begin
         $display("FAIL raw1_read d8=%h d3=%h required 7f7f7f7f/0", r8, r3); n_bad++; end
   endtask

   task automatic test_cyc_drop();
      cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 30'd1; sel = 4'hF;
      tick();
      bus_idle();
      #1;
      n_cmp++; if (ack8 !== 1'b0 || rdat8 !== 32'h0) begin
         $display("FAIL cyc_drop ack=%b rdat=%h required 0/0", ack8, rdat8); n_bad++; end
      tick();
   endtask

   task automatic test_scan();
      logic [2:0] exp_an [4];
      int cnt;
      exp_an[0] = 3'b110; exp_an[1] = 3'b101; exp_an[2] = 3'b011; exp_an[3] = 3'b110;
      do_reset();
      n_cmp++; if (san3 !== 3'b111 || sseg3 !== 8'hFF) begin
         $display("FAIL scan_reset an=%b seg=%h required 111/ff", san3, sseg3); n_bad++; end
      rst_n = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         tick();
         n_cmp++; if (san3 !== exp_an[(e-1)/4]) begin
            $display("FAIL scan_an_e%0d got %b required %b", e, san3, exp_an[(e-1)/4]); n_bad++; end
         if (e == 2) begin
            n_cmp++; if (sseg3 !== 8'hC0) begin
               $display("FAIL scan_seg got %h required c0", sseg3); n_bad++; end
         end
      end
      wb_write(2'd1, 32'h0000_0000, 4'hF);
      tick();
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         tick();
         if (san3 !== 3'b111) cnt++;
      end
      n_cmp++; if (cnt !== 2) begin
         $display("FAIL pwm_bright0 active=%0d required 2", cnt); n_bad++; end
      wb_write(2'd1, 32'h0700_0000, 4'hF);
      tick();
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         tick();
         if (san3 !== 3'b111) cnt++;
      end
      n_cmp++; if (cnt !== 16) begin
         $display("FAIL pwm_bright7 active=%0d required 16", cnt); n_bad++; end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r8, r3;
      cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 30'd0; wdat = 32'hDEAD_BEEF; sel = 4'hF;
      tick();
      n_cmp++; if (ack8 !== 1'b1 || disp8[0] !== 7'h0E) begin
         $display("FAIL mid_before ack=%b d0=%h required 1/0e", ack8, disp8[0]); n_bad++; end
      stb = 1'b0; we = 1'b0;
      rst_n = 1'b0;
      tick();
      n_cmp++; if (ack8 !== 1'b0 || disp8[0] !== 7'h7F) begin
         $display("FAIL mid_reset ack=%b d0=%h required 0/7f", ack8, disp8[0]); n_bad++; end
      bus_idle();
      rst_n = 1'b1;
      tick();
      wb_read(2'd0, r8, r3);
      n_cmp++; if (r8 !== 32'h0 || r3 !== 32'h0) begin
         $display("FAIL mid_data d8=%h d3=%h required 0/0", r8, r3); n_bad++; end
      n_cmp++; if (disp8[0] !== 7'h40) begin
         $display("FAIL mid_disp d0=%h required 40", disp8[0]); n_bad++; end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus_idle();
      test_reset();
      test_hex();
      test_back_to_back();
      test_ctrl_raw();
      test_cyc_drop();
      test_scan();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
